// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, ALU op codes shared with the ALU, and the decoded bundle struct
package rv32i_pkg;
  localparam logic [6:0] OPC_OP = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  typedef enum logic [5:0] {
    ALU_ADD = 6'h00, ALU_SUB = 6'h01, ALU_SLL = 6'h02, ALU_SLT = 6'h03,
    ALU_SLTU = 6'h04, ALU_XOR = 6'h05, ALU_SRL = 6'h06, ALU_SRA = 6'h07,
    ALU_OR = 6'h08, ALU_AND = 6'h09, ALU_ADDI = 6'h0A, ALU_SLLI = 6'h0B,
    ALU_SLTI = 6'h0C, ALU_SLTIU = 6'h0D, ALU_XORI = 6'h0E, ALU_SRLI = 6'h0F,
    ALU_ORI = 6'h10, ALU_ANDI = 6'h11, ALU_LUI = 6'h12,
    ALU_BEQ = 6'h1A, ALU_BNE = 6'h1B, ALU_BLT = 6'h1C, ALU_BGE = 6'h1D
  } alu_op_e;
  typedef struct packed {
    alu_op_e alu_cntrl;
    logic [31:0] imm_val;
    logic [4:0] shift_amount;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic reg_write;
    logic is_branch;
    logic illegal;
  } decode_bundle_t;
endpackage

// File: rtl/rv32i_decode_stage_if.sv
// rv32i_decode_stage_if: fetch-side (in_valid/in_ready/instr/flush) and execute-side (out_valid/out_ready + bundle, illegal_cnt) handshake bus
interface rv32i_decode_stage_if #(parameter int CNT_W = 16);
  logic in_valid;
  logic in_ready;
  logic [31:0] instr;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [5:0] alu_cntrl;
  logic [31:0] imm_val;
  logic [4:0] shift_amount;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [4:0] rd_addr;
  logic reg_write;
  logic is_branch;
  logic illegal;
  logic [CNT_W-1:0] illegal_cnt;
  modport slave (
    input in_valid, instr, flush, out_ready,
    output in_ready, out_valid, alu_cntrl, imm_val, shift_amount, rs1_addr, rs2_addr, rd_addr,
    reg_write, is_branch, illegal, illegal_cnt
  );
  modport master (
    output in_valid, instr, flush, out_ready,
    input in_ready, out_valid, alu_cntrl, imm_val, shift_amount, rs1_addr, rs2_addr, rd_addr,
    reg_write, is_branch, illegal, illegal_cnt
  );
endinterface

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: combinational instr[31:0] -> decode_bundle_t, unsupported encodings flagged illegal with neutral controls
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0]    instr,
  output decode_bundle_t bundle
);
  logic [6:0] f7;
  logic [2:0] f3;
  alu_op_e op;
  logic [31:0] imm;
  logic [4:0] sh;
  logic legal;
  logic br;
  assign f7 = instr[31:25];
  assign f3 = instr[14:12];
  always_comb begin
    op = ALU_ADD;
    imm = '0;
    sh = '0;
    legal = 1'b1;
    br = 1'b0;
    case (instr[6:0])
      OPC_OP:
        case ({f7, f3})
          {7'h00, 3'd0}: op = ALU_ADD;
          {7'h20, 3'd0}: op = ALU_SUB;
          {7'h00, 3'd1}: op = ALU_SLL;
          {7'h00, 3'd2}: op = ALU_SLT;
          {7'h00, 3'd3}: op = ALU_SLTU;
          {7'h00, 3'd4}: op = ALU_XOR;
          {7'h00, 3'd5}: op = ALU_SRL;
          {7'h20, 3'd5}: op = ALU_SRA;
          {7'h00, 3'd6}: op = ALU_OR;
          {7'h00, 3'd7}: op = ALU_AND;
          default: legal = 1'b0;
        endcase
      OPC_OP_IMM: begin
        imm = {{20{instr[31]}}, instr[31:20]};
        sh = (f3 == 3'd1 || f3 == 3'd5) ? instr[24:20] : 5'd0;
        case (f3)
          3'd0: op = ALU_ADDI;
          3'd1: begin
            op = ALU_SLLI;
            legal = f7 == 7'h00;
          end
          3'd2: op = ALU_SLTI;
          3'd3: op = ALU_SLTIU;
          3'd4: op = ALU_XORI;
          3'd5: begin
            op = f7[5] ? ALU_SRA : ALU_SRLI;
            legal = f7 == 7'h00 || f7 == 7'h20;
          end
          3'd6: op = ALU_ORI;
          default: op = ALU_ANDI;
        endcase
      end
      OPC_LUI: begin
        op = ALU_LUI;
        imm = {12'h000, instr[31:12]};
      end
      OPC_BRANCH: begin
        br = 1'b1;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          3'd0: op = ALU_BEQ;
          3'd1: op = ALU_BNE;
          3'd4: op = ALU_BLT;
          3'd5: op = ALU_BGE;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    bundle = '0;
    bundle.alu_cntrl = legal ? op : ALU_ADD;
    bundle.imm_val = legal ? imm : 32'h0;
    bundle.shift_amount = legal ? sh : 5'd0;
    bundle.rs1_addr = instr[19:15];
    bundle.rs2_addr = instr[24:20];
    bundle.rd_addr = instr[11:7];
    bundle.reg_write = legal & ~br & (|instr[11:7]);
    bundle.is_branch = legal & br;
    bundle.illegal = ~legal;
  end
endmodule

// File: rtl/rv32i_decode_stage.sv
// rv32i_decode_stage: clk, rst_n (async low), bus.slave; decoder + output register + skid entry, flush, saturating illegal counter
module rv32i_decode_stage
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  rv32i_decode_stage_if.slave bus
);
  decode_bundle_t dec;
  decode_bundle_t out_b;
  decode_bundle_t skid_b;
  logic out_valid;
  logic skid_valid;
  logic [CNT_W-1:0] cnt;
  logic drain;
  logic in_fire;
  logic out_fire;
  rv32i_decoder u_dec (
    .instr (bus.instr),
    .bundle(dec)
  );
  assign out_fire = out_valid & bus.out_ready;
  assign drain = ~out_valid | bus.out_ready;
  assign in_fire = bus.in_valid & ~skid_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_b <= '0;
      skid_b <= '0;
      cnt <= '0;
    end else begin
      if (out_fire && out_b.illegal && !(&cnt)) cnt <= cnt + CNT_W'(1);
      if (bus.flush) begin
        out_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (drain) begin
        if (skid_valid) begin
          out_b <= skid_b;
          out_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= in_fire;
          if (in_fire) out_b <= dec;
        end
      end else if (in_fire) begin
        skid_b <= dec;
        skid_valid <= 1'b1;
      end
    end
  end
  assign bus.in_ready = ~skid_valid;
  assign bus.out_valid = out_valid;
  assign bus.alu_cntrl = out_b.alu_cntrl;
  assign bus.imm_val = out_b.imm_val;
  assign bus.shift_amount = out_b.shift_amount;
  assign bus.rs1_addr = out_b.rs1_addr;
  assign bus.rs2_addr = out_b.rs2_addr;
  assign bus.rd_addr = out_b.rd_addr;
  assign bus.reg_write = out_b.reg_write;
  assign bus.is_branch = out_b.is_branch;
  assign bus.illegal = out_b.illegal;
  assign bus.illegal_cnt = cnt;
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb_rv32i_decode_stage: scoreboard bench for the decode stage, counter narrowed so saturation is reachable
module tb_rv32i_decode_stage;
  import rv32i_pkg::*;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rv32i_decode_stage_if #(.CNT_W(CNT_W)) bus ();
  rv32i_decode_stage #(.CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  decode_bundle_t q[$];
  decode_bundle_t exp_in;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  localparam logic [31:0] I_ADD = 32'h002081B3, I_ADDI = 32'hFFF00093, I_LUI = 32'h12345237;
  localparam logic [31:0] I_SRAI = 32'h40715113, I_SUB = 32'h407302B3, I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BNE = 32'hFE001EE3, I_JAL = 32'h0000006F, I_BLTU = 32'h00006063;
  localparam logic [31:0] I_ADD_X0 = 32'h00208033;
  function automatic decode_bundle_t mk(input logic [5:0] alu, input logic [31:0] imm,
                                        input logic [4:0] sh, rs1, rs2, rd,
                                        input logic rw, br, ill);
    decode_bundle_t b;
    b.alu_cntrl = alu_op_e'(alu);
    b.imm_val = imm;
    b.shift_amount = sh;
    b.rs1_addr = rs1;
    b.rs2_addr = rs2;
    b.rd_addr = rd;
    b.reg_write = rw;
    b.is_branch = br;
    b.illegal = ill;
    return b;
  endfunction
  function automatic decode_bundle_t act();
    decode_bundle_t b;
    b.alu_cntrl = alu_op_e'(bus.alu_cntrl);
    b.imm_val = bus.imm_val;
    b.shift_amount = bus.shift_amount;
    b.rs1_addr = bus.rs1_addr;
    b.rs2_addr = bus.rs2_addr;
    b.rd_addr = bus.rd_addr;
    b.reg_write = bus.reg_write;
    b.is_branch = bus.is_branch;
    b.illegal = bus.illegal;
    return b;
  endfunction
  decode_bundle_t e_add, e_addi, e_lui, e_srai, e_sub, e_beq, e_bne, e_jal, e_bltu, e_add_x0;
  task automatic tick();
    decode_bundle_t a;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      a = act();
      checks++;
      pops++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output act=%h exp=none", a);
      end else begin
        if (a !== q[0]) begin
          errors++;
          $display("FAIL out_bundle act=%h exp=%h", a, q[0]);
        end
        void'(q.pop_front());
      end
    end
    if (bus.in_valid && bus.in_ready && !bus.flush) q.push_back(exp_in);
    @(posedge clk);
    #1;
  endtask
  task automatic present(input logic [31:0] i, input decode_bundle_t e);
    bus.in_valid = 1'b1;
    bus.instr = i;
    exp_in = e;
  endtask
  task automatic send_one(input string name, input logic [31:0] i, input decode_bundle_t e);
    present(i, e);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency out_valid=%b exp=1", name, bus.out_valid);
    end
    tick();
  endtask
  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid act=%b exp=0", bus.out_valid);
    end
    if (bus.illegal_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt act=%h exp=0", bus.illegal_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready act=%b exp=1", bus.in_ready);
    end
  endtask
  task automatic test_alu_ops();
    send_one("add", I_ADD, e_add);
    send_one("addi", I_ADDI, e_addi);
    send_one("sub", I_SUB, e_sub);
    send_one("add_x0", I_ADD_X0, e_add_x0);
    send_one("beq", I_BEQ, e_beq);
    send_one("bne", I_BNE, e_bne);
  endtask
  task automatic test_back_to_back();
    int p0;
    p0 = pops;
    bus.out_ready = 1'b1;
    present(I_LUI, e_lui);
    tick();
    present(I_SRAI, e_srai);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (pops - p0 !== 2) begin
      errors++;
      $display("FAIL b2b_count act=%0d exp=2", pops - p0);
    end
  endtask
  task automatic test_back_pressure();
    logic [31:0] si[4];
    decode_bundle_t se[4];
    decode_bundle_t snap;
    int idx, p0;
    logic acc;
    si = '{I_ADD, I_SUB, I_BEQ, I_ADDI};
    se = '{e_add, e_sub, e_beq, e_addi};
    p0 = pops;
    bus.out_ready = 1'b0;
    present(si[0], se[0]);
    tick();
    present(si[1], se[1]);
    tick();
    snap = act();
    checks += 2;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready act=%b exp=0", bus.in_ready);
    end
    if (snap !== e_add || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_head act=%h exp=%h", snap, e_add);
    end
    present(si[2], se[2]);
    tick();
    tick();
    checks++;
    if (act() !== snap || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold act=%h exp=%h", act(), snap);
    end
    idx = 2;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && !(idx == 4 && q.size() == 0); c++) begin
      if (idx < 4) present(si[idx], se[idx]);
      else bus.in_valid = 1'b0;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    checks += 2;
    if (idx != 4 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout accepted=%0d pending=%0d exp=4/0", idx, q.size());
    end
    if (pops - p0 !== 4) begin
      errors++;
      $display("FAIL bp_count act=%0d exp=4", pops - p0);
    end
  endtask
  task automatic test_illegal();
    send_one("jal", I_JAL, e_jal);
    checks++;
    if (bus.illegal_cnt !== 4'd1) begin
      errors++;
      $display("FAIL illegal_cnt act=%0d exp=1", bus.illegal_cnt);
    end
  endtask
  task automatic test_flush();
    bus.out_ready = 1'b0;
    present(I_BLTU, e_bltu);
    tick();
    present(I_ADD, e_add);
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_full act=%b exp=0", bus.in_ready);
    end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    present(I_SUB, e_sub);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    checks += 3;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear out_valid=%b in_ready=%b exp=0/1", bus.out_valid, bus.in_ready);
    end
    if (bus.illegal_cnt !== 4'd2) begin
      errors++;
      $display("FAIL flush_cnt act=%0d exp=2", bus.illegal_cnt);
    end
    bus.flush = 1'b1;
    present(I_ADD, e_add);
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop act=%b exp=0", bus.out_valid);
    end
    send_one("post_flush", I_LUI, e_lui);
  endtask
  task automatic test_saturate();
    for (int k = 0; k < 13; k++) send_one("bltu", I_BLTU, e_bltu);
    checks++;
    if (bus.illegal_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_reach act=%0d exp=15", bus.illegal_cnt);
    end
    send_one("jal_sat", I_JAL, e_jal);
    checks++;
    if (bus.illegal_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold act=%0d exp=15", bus.illegal_cnt);
    end
  endtask
  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    present(I_ADD, e_add);
    tick();
    present(I_SUB, e_sub);
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.illegal_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset out_valid=%b in_ready=%b cnt=%0d exp=0/1/0", bus.out_valid,
               bus.in_ready, bus.illegal_cnt);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_one("post_reset", I_SRAI, e_srai);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    e_add = mk(6'h00, 32'h0, 5'd0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    e_addi = mk(6'h0A, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd31, 5'd1, 1'b1, 1'b0, 1'b0);
    e_lui = mk(6'h12, 32'h00012345, 5'd0, 5'd8, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    e_srai = mk(6'h07, 32'h00000407, 5'd7, 5'd2, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0);
    e_sub = mk(6'h01, 32'h0, 5'd0, 5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0);
    e_beq = mk(6'h1A, 32'h00000008, 5'd0, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b0);
    e_bne = mk(6'h1B, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 5'd29, 1'b0, 1'b1, 1'b0);
    e_jal = mk(6'h00, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    e_bltu = mk(6'h00, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    e_add_x0 = mk(6'h00, 32'h0, 5'd0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    exp_in = '0;
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_back_pressure();
    test_illegal();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
